// File: rtl/config_frame_writer_pkg.sv
// Shared constants, header field positions and FSM state encoding for the
// configuration frame writer.
package config_writer_pkg;

   localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

   localparam int END_BIT = 31;
   localparam int COL_MSB = 23;
   localparam int COL_LSB = 16;
   localparam int FRM_MSB = 4;
   localparam int FRM_LSB = 0;
   localparam int COL_W   = COL_MSB - COL_LSB + 1;
   localparam int FRM_W   = FRM_MSB - FRM_LSB + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      DATA   = 3'd2,
      SETUP  = 3'd3,
      STROBE = 3'd4,
      HOLD   = 3'd5
   } state_t;

   function automatic logic is_sync(input logic [31:0] word);
      return (word == SYNC_WORD);
   endfunction

endpackage

// File: rtl/config_frame_writer_strobe.sv
// Decodes (column, frame) into a registered one-hot latch-enable vector;
// the vector is all zero whenever en is low.
module frame_strobe_decoder
   import config_writer_pkg::*;
#(
   parameter int NUM_COLUMNS    = 10,
   parameter int FRAMES_PER_COL = 20
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [COL_W-1:0]                      col,
   input  logic [FRM_W-1:0]                      frame,
   input  logic                                  en,
   output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] strobe
);

   localparam int NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;
   localparam int IDX_W       = $clog2(NUM_STROBES);

   logic [IDX_W-1:0]       idx_s;
   logic [NUM_STROBES-1:0] onehot_s;
   logic [NUM_STROBES-1:0] strobe_r;

   // Flat strobe index and its one-hot image; col/frame are range-checked upstream.
   always_comb begin
      idx_s           = IDX_W'(32'(col) * 32'(FRAMES_PER_COL) + 32'(frame));
      onehot_s        = '0;
      onehot_s[idx_s] = 1'b1;
   end

   // Register the enable so the latch strobe comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_r <= '0;
      end else if (en) begin
         strobe_r <= onehot_s;
      end else begin
         strobe_r <= '0;
      end
   end

   assign strobe = strobe_r;

endmodule

// File: rtl/config_frame_writer.sv
// Assembles a NUM_ROWS-word configuration frame from a 32-bit word stream and
// fires one latch strobe with a setup cycle before and a hold cycle after it.
module config_frame_writer
   import config_writer_pkg::*;
#(
   parameter int NUM_ROWS       = 9,
   parameter int NUM_COLUMNS    = 10,
   parameter int FRAMES_PER_COL = 20
) (
   input  logic                                  CLK,
   input  logic                                  RESET,
   input  logic [31:0]                           s_data,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   output logic [NUM_ROWS*32-1:0]                FrameData,
   output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err
);

   localparam int FD_W  = NUM_ROWS * 32;
   localparam int ROW_W = $clog2(NUM_ROWS + 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

   state_t            state_r;
   state_t            next_state_s;
   logic [ROW_W-1:0]  row_cnt_r;
   logic [COL_W-1:0]  col_r;
   logic [FRM_W-1:0]  frame_r;
   logic              discard_r;
   logic [FD_W-1:0]   frame_data_r;
   logic              s_ready_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;

   logic              acc_s;
   logic              shift_s;
   logic              hdr_load_s;
   logic              hdr_bad_s;
   logic              end_s;
   logic              hdr_range_bad_s;
   logic [COL_W-1:0]  hdr_col_s;
   logic [FRM_W-1:0]  hdr_frm_s;

   assign hdr_col_s       = s_data[COL_MSB:COL_LSB];
   assign hdr_frm_s       = s_data[FRM_MSB:FRM_LSB];
   assign hdr_range_bad_s = (32'(hdr_col_s) >= 32'(NUM_COLUMNS)) ||
                            (32'(hdr_frm_s) >= 32'(FRAMES_PER_COL));
   assign acc_s           = s_valid && s_ready_r;

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and per-word datapath controls.
   always_comb begin
      next_state_s = state_r;
      shift_s      = 1'b0;
      hdr_load_s   = 1'b0;
      hdr_bad_s    = 1'b0;
      end_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (acc_s && is_sync(s_data)) begin
               next_state_s = HEADER;
            end else begin
               next_state_s = IDLE;
            end
         end
         HEADER: begin
            if (!acc_s || is_sync(s_data)) begin
               next_state_s = HEADER;
            end else if (s_data[END_BIT]) begin
               end_s        = 1'b1;
               next_state_s = IDLE;
            end else if (hdr_range_bad_s) begin
               hdr_bad_s    = 1'b1;
               next_state_s = DATA;
            end else begin
               hdr_load_s   = 1'b1;
               next_state_s = DATA;
            end
         end
         DATA: begin
            if (acc_s) begin
               shift_s = 1'b1;
               if (row_cnt_r == ROW_LAST) begin
                  next_state_s = discard_r ? HEADER : SETUP;
               end else begin
                  next_state_s = DATA;
               end
            end else begin
               next_state_s = DATA;
            end
         end
         SETUP:   next_state_s = STROBE;
         STROBE:  next_state_s = HOLD;
         HOLD:    next_state_s = HEADER;
         default: next_state_s = IDLE;
      endcase
   end

   // Frame shift register, header capture and registered status outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         row_cnt_r    <= '0;
         col_r        <= '0;
         frame_r      <= '0;
         discard_r    <= 1'b0;
         frame_data_r <= '0;
         s_ready_r    <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         s_ready_r <= (next_state_s == IDLE) || (next_state_s == HEADER) ||
                      (next_state_s == DATA);
         busy_r    <= (next_state_s != IDLE);
         done_r    <= end_s;
         if (hdr_bad_s) begin
            err_r <= 1'b1;
         end
         if (hdr_load_s) begin
            col_r   <= hdr_col_s;
            frame_r <= hdr_frm_s;
         end
         if (hdr_load_s || hdr_bad_s) begin
            discard_r <= hdr_bad_s;
            row_cnt_r <= '0;
         end
         // First word of a frame ends up in the top row slice.
         if (shift_s) begin
            frame_data_r <= {frame_data_r[FD_W-33:0], s_data};
            row_cnt_r    <= row_cnt_r + ROW_W'(1);
         end
      end
   end

   frame_strobe_decoder #(
      .NUM_COLUMNS   (NUM_COLUMNS),
      .FRAMES_PER_COL(FRAMES_PER_COL)
   ) u_strobe (
      .clk   (CLK),
      .rst   (RESET),
      .col   (col_r),
      .frame (frame_r),
      .en    (state_r == SETUP),
      .strobe(FrameStrobe)
   );

   assign s_ready   = s_ready_r;
   assign FrameData = frame_data_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: word-level reference parser,
// header/strobe vector table, and hand-written multi-cycle sequences.
module tb_config_frame_writer;

   localparam int NR  = 9;
   localparam int NC  = 10;
   localparam int FPC = 20;
   localparam int NS  = NC * FPC;
   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic [31:0]    s_data = 32'h0;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [287:0]   FrameData;
   logic [NS-1:0]  FrameStrobe;
   logic           busy;
   logic           done;
   logic           err;

   always #5 CLK = ~CLK;

   config_frame_writer #(.NUM_ROWS(NR), .NUM_COLUMNS(NC), .FRAMES_PER_COL(FPC)) dut (
      .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .err(err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- monitor (sole writer of its variables) ----------------
   int            seen_idx[$];
   logic [287:0]  seen_fd[$];
   int            done_seen = 0;
   int            bad_onehot = 0;
   int            bad_width = 0;
   int            bad_fd = 0;
   int            bad_done = 0;
   logic [NS-1:0] prev_fs = '0;
   logic [287:0]  prev_fd = '0;
   logic          prev_done = 1'b0;

   always @(negedge CLK) begin
      if (FrameStrobe != '0) begin
         int idx;
         idx = -1;
         for (int i = 0; i < NS; i++) if (FrameStrobe[i]) idx = i;
         if ($countones(FrameStrobe) != 1) bad_onehot++;
         if (prev_fs != '0) bad_width++;
         seen_idx.push_back(idx);
         seen_fd.push_back(FrameData);
      end
      if (!RESET && (FrameStrobe != '0 || prev_fs != '0) && FrameData != prev_fd) bad_fd++;
      if (done) begin
         done_seen++;
         if (prev_done) bad_done++;
      end
      prev_fs   = FrameStrobe;
      prev_fd   = FrameData;
      prev_done = done;
   end

   // ---------------- word-level reference model ----------------
   int            m_mode;      // 0 hunting for sync, 1 expecting header, 2 collecting rows
   logic [31:0]   m_words[$];
   int            m_col, m_frm;
   bit            m_disc, m_err;
   int            m_done;
   logic [287:0]  m_fd;
   int            exp_idx_q[$];
   logic [287:0]  exp_fd_q[$];
   int            done_base = 0;
   int            seen_rd = 0;

   task automatic model_reset();
      m_mode = 0; m_words.delete(); m_disc = 0; m_err = 0; m_done = 0; m_fd = '0;
      exp_idx_q.delete(); exp_fd_q.delete();
      done_base = done_seen;
      seen_rd   = seen_idx.size();
   endtask

   task automatic mw(input logic [31:0] w);
      case (m_mode)
         0: if (w == SYNC) m_mode = 1;
         1: begin
            if (w != SYNC) begin
               if (w[31]) begin
                  m_done++;
                  m_mode = 0;
               end else begin
                  m_col  = int'(w[23:16]);
                  m_frm  = int'(w[4:0]);
                  m_disc = (m_col >= NC) || (m_frm >= FPC);
                  if (m_disc) m_err = 1;
                  m_words.delete();
                  m_mode = 2;
               end
            end
         end
         default: begin
            m_words.push_back(w);
            if (m_words.size() == NR) begin
               for (int r = 0; r < NR; r++) m_fd[(NR-1-r)*32 +: 32] = m_words[r];
               if (!m_disc) begin
                  exp_idx_q.push_back(m_col * FPC + m_frm);
                  exp_fd_q.push_back(m_fd);
               end
               m_mode = 1;
            end
         end
      endcase
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [31:0] w, input bit gap);
      int b;
      b = 0;
      if (gap) begin
         while ($urandom_range(0, 1) == 1 && b < 8) begin
            s_valid = 1'b0;
            @(negedge CLK);
            b++;
         end
      end
      s_data = w; s_valid = 1'b1; b = 0;
      while (!s_ready && b < 50) begin
         @(negedge CLK);
         b++;
      end
      if (!s_ready) begin
         chk("s_ready_within_bound", 288'(s_ready), 288'(1));
         s_valid = 1'b0;
      end else begin
         @(negedge CLK);
         s_valid = 1'b0;
         mw(w);
      end
   endtask

   task automatic send_frame(input logic [31:0] hdr, input bit gap);
      send(hdr, gap);
      for (int i = 0; i < NR; i++) send($urandom, gap);
   endtask

   task automatic compare_strobes();
      while (seen_rd < seen_idx.size()) begin
         if (exp_idx_q.size() == 0) begin
            chk("unexpected_strobe_count", 288'(seen_idx.size() - seen_rd), 288'(0));
            seen_rd = seen_idx.size();
         end else begin
            chk("strobe_bit", 288'(seen_idx[seen_rd]), 288'(exp_idx_q.pop_front()));
            chk("strobe_framedata", seen_fd[seen_rd], exp_fd_q.pop_front());
            seen_rd++;
         end
      end
   endtask

   task automatic do_reset();
      compare_strobes();
      s_valid = 1'b0;
      RESET   = 1'b1;
      tick(2);
      RESET = 1'b0;
      model_reset();
   endtask

   task automatic finish_check(input string nm);
      tick(6);
      compare_strobes();
      chk({nm, "_missing_strobes"}, 288'(exp_idx_q.size()), 288'(0));
      chk({nm, "_done_count"}, 288'(done_seen - done_base), 288'(m_done));
      chk({nm, "_err"}, 288'(err), 288'(m_err));
      chk({nm, "_onehot"}, 288'(bad_onehot), 288'(0));
      chk({nm, "_strobe_width"}, 288'(bad_width), 288'(0));
      chk({nm, "_fd_stable"}, 288'(bad_fd), 288'(0));
      chk({nm, "_done_width"}, 288'(bad_done), 288'(0));
   endtask

   typedef struct {
      logic [31:0] hdr;
      int          exp_bit;   // -1: no strobe expected
      bit          exp_err;
   } vec_t;

   vec_t          tbl[8];
   logic [31:0]   words[$];
   int            ref_idx[$];
   logic [287:0]  ref_fd[$];
   logic [NS-1:0] exp_fs;
   logic [287:0]  hold_fd;

   initial begin
      tbl[0] = '{32'h0002_0005, 45, 1'b0};
      tbl[1] = '{32'h0000_0000, 0, 1'b0};
      tbl[2] = '{32'h0009_0013, 199, 1'b0};
      tbl[3] = '{32'h000A_0000, -1, 1'b1};
      tbl[4] = '{32'h0000_0014, -1, 1'b1};
      tbl[5] = '{32'h0003_0013, 79, 1'b0};
      tbl[6] = '{32'h7F03_FFE7, 67, 1'b0};
      tbl[7] = '{32'h00FF_0001, -1, 1'b1};

      // Reset values.
      tick(2);
      chk("rst_s_ready", 288'(s_ready), 288'(1));
      chk("rst_framedata", FrameData, 288'(0));
      chk("rst_strobe", 288'(FrameStrobe), 288'(0));
      chk("rst_busy", 288'(busy), 288'(0));
      chk("rst_done", 288'(done), 288'(0));
      chk("rst_err", 288'(err), 288'(0));
      RESET = 1'b0;
      model_reset();

      // Basic frame with exact strobe timing.
      send(SYNC, 1'b0);
      send(32'h0002_0005, 1'b0);
      for (int i = 1; i <= NR; i++) send(32'(i), 1'b0);
      exp_fs = '0; exp_fs[45] = 1'b1;
      chk("t1_setup_ready", 288'(s_ready), 288'(0));
      chk("t1_setup_strobe", 288'(FrameStrobe), 288'(0));
      tick(1);
      chk("t1_strobe_bit45", 288'(FrameStrobe), 288'(exp_fs));
      chk("t1_strobe_ready", 288'(s_ready), 288'(0));
      tick(1);
      chk("t1_hold_strobe", 288'(FrameStrobe), 288'(0));
      chk("t1_hold_ready", 288'(s_ready), 288'(0));
      tick(1);
      chk("t1_ready_back", 288'(s_ready), 288'(1));
      chk("t1_top_row", 288'(FrameData[287:256]), 288'(1));
      chk("t1_low_row", 288'(FrameData[31:0]), 288'(9));
      chk("t1_busy", 288'(busy), 288'(1));
      finish_check("t1");

      // Junk before sync, then a frame with a stall in the middle.
      do_reset();
      repeat (3) send(32'hDEAD_BEEF, 1'b0);
      chk("t2_busy_idle", 288'(busy), 288'(0));
      send(SYNC, 1'b0);
      send(32'h0007_0003, 1'b0);
      for (int i = 0; i < 4; i++) send($urandom, 1'b0);
      hold_fd = FrameData;
      tick(5);
      chk("t2_stall_fd", FrameData, hold_fd);
      chk("t2_stall_busy", 288'(busy), 288'(1));
      for (int i = 0; i < 5; i++) send($urandom, 1'b0);
      finish_check("t2");

      // Out-of-range header: data loads, no strobe, err sticks through a good frame.
      do_reset();
      send(SYNC, 1'b0);
      send_frame(32'h000A_0000, 1'b0);
      tick(4);
      chk("t3_err", 288'(err), 288'(1));
      chk("t3_fd_new_words", FrameData, m_fd);
      chk("t3_busy_header", 288'(busy), 288'(1));
      send_frame(32'h0000_0000, 1'b0);
      finish_check("t3");
      chk("t3_err_sticky", 288'(err), 288'(1));

      // Header table.
      foreach (tbl[k]) begin
         int base;
         do_reset();
         base = seen_idx.size();
         send(SYNC, 1'b0);
         send_frame(tbl[k].hdr, 1'b0);
         tick(6);
         chk("tbl_strobe_count", 288'(seen_idx.size() - base), 288'(tbl[k].exp_bit >= 0 ? 1 : 0));
         if (tbl[k].exp_bit >= 0 && seen_idx.size() > base)
            chk("tbl_strobe_bit", 288'(seen_idx[base]), 288'(tbl[k].exp_bit));
         chk("tbl_err", 288'(err), 288'(tbl[k].exp_err));
         finish_check("tbl");
      end

      // Gapless vs gapped back-to-back frames.
      words.delete();
      words.push_back(SYNC);
      for (int f = 0; f < 2; f++) begin
         words.push_back({8'h00, 8'($urandom_range(0, NC-1)), 11'h0, 5'($urandom_range(0, FPC-1))});
         for (int i = 0; i < NR; i++) words.push_back($urandom);
      end
      for (int pass = 0; pass < 2; pass++) begin
         int base;
         do_reset();
         base = seen_idx.size();
         foreach (words[i]) send(words[i], pass == 1);
         tick(6);
         chk("t4_strobe_count", 288'(seen_idx.size() - base), 288'(2));
         if (pass == 0) begin
            ref_idx.delete(); ref_fd.delete();
            for (int i = base; i < seen_idx.size(); i++) begin
               ref_idx.push_back(seen_idx[i]);
               ref_fd.push_back(seen_fd[i]);
            end
         end else begin
            for (int i = 0; i < ref_idx.size() && base + i < seen_idx.size(); i++) begin
               chk("t4_gap_idx", 288'(seen_idx[base+i]), 288'(ref_idx[i]));
               chk("t4_gap_fd", seen_fd[base+i], ref_fd[i]);
            end
         end
         finish_check("t4");
      end

      // Randomised stream against the reference parser.
      do_reset();
      for (int it = 0; it < 40; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r % 5 == 0) send($urandom, 1'b1);
         if ($urandom_range(0, 3) != 0) send(SYNC, 1'b1);
         if (r < 8) send(32'h8000_0000 | 32'($urandom_range(0, 255)), 1'b1);
         else if (r < 16) send_frame({8'h00, 8'($urandom_range(NC, 255)), 16'h0}, 1'b1);
         else if (r < 22) send_frame({8'h00, 8'($urandom_range(0, NC-1)), 11'h0, 5'($urandom_range(FPC, 31))}, 1'b1);
         else send_frame({1'b0, 7'($urandom), 8'($urandom_range(0, NC-1)), 11'($urandom), 5'($urandom_range(0, FPC-1))}, 1'b1);
      end
      finish_check("rand");

      // Reset during STROBE.
      do_reset();
      send(SYNC, 1'b0);
      send_frame(32'h0004_0001, 1'b0);
      begin
         int b;
         b = 0;
         while (FrameStrobe == '0 && b < 10) begin
            tick(1);
            b++;
         end
      end
      chk("t5_strobe_seen_before_reset", 288'(FrameStrobe != '0), 288'(1));
      RESET = 1'b1;
      tick(1);
      chk("t5_strobe_drop", 288'(FrameStrobe), 288'(0));
      chk("t5_fd_clear", FrameData, 288'(0));
      chk("t5_busy_idle", 288'(busy), 288'(0));
      chk("t5_ready", 288'(s_ready), 288'(1));
      compare_strobes();
      tick(1);
      RESET = 1'b0;
      model_reset();
      send_frame(32'h0004_0001, 1'b0);
      chk("t5_nosync_busy", 288'(busy), 288'(0));
      chk("t5_nosync_fd", FrameData, 288'(0));
      finish_check("t5");

      // End-of-config header.
      do_reset();
      send(SYNC, 1'b0);
      send_frame(32'h0001_0002, 1'b0);
      tick(4);
      send(32'h8000_0000, 1'b0);
      chk("t6_done_pulse", 288'(done), 288'(1));
      chk("t6_busy", 288'(busy), 288'(0));
      chk("t6_ready", 288'(s_ready), 288'(1));
      tick(1);
      chk("t6_done_low", 288'(done), 288'(0));
      finish_check("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
